// File: rtl/spi_tx_arbiter_if.sv
// Bundles the two requester ports and the shifter port of spi_tx_arbiter.
// master is the arbiter side; slave is the requester/shifter environment side.
interface spi_tx_arbiter_if #(
  parameter int unsigned LEN_W = 4
);
  logic             req0;
  logic [LEN_W-1:0] len0;
  logic [7:0]       data0;
  logic             rd0;
  logic             done0;

  logic             req1;
  logic [LEN_W-1:0] len1;
  logic [7:0]       data1;
  logic             rd1;
  logic             done1;

  logic [1:0]       grant;
  logic             spi_cs;
  logic [7:0]       spi_data;
  logic             spi_valid;
  logic             busy;
  logic             err;

  modport master (
    input  req0, len0, data0, req1, len1, data1, spi_valid,
    output rd0, done0, rd1, done1, grant, spi_cs, spi_data, busy, err
  );

  modport slave (
    output req0, len0, data0, req1, len1, data1, spi_valid,
    input  rd0, done0, rd1, done1, grant, spi_cs, spi_data, busy, err
  );
endinterface

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter sharing one SPI byte shifter between two frame requesters,
// with a one-byte prefetch, per-byte timeout abort and a chip-select gap between frames.
module spi_tx_arbiter #(
  parameter int unsigned CS_GAP  = 4,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned LEN_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  spi_tx_arbiter_if.master bus
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned TMO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GAP_W  = (CS_GAP > 2) ? $clog2(CS_GAP) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t              state;
  logic [1:0]          grant_q;
  logic                cs_q;
  logic [DATA_W-1:0]   data_q;
  logic [1:0]          rd_q;
  logic [1:0]          done_q;
  logic                err_q;
  logic                busy_q;
  logic                last_one;    // 1: requester 1 was granted most recently
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    remaining;   // bytes still to be placed on spi_data
  logic [DATA_W-1:0]   pf_data;
  logic                pf_full;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [GAP_W-1:0]    gap_cnt;

  logic                pick1;
  logic [1:0]          pick_oh;
  logic [LEN_W-1:0]    len_sel;
  logic [DATA_W-1:0]   data_sel;
  logic                rd_pending;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign pick1      = bus.req1 && (!bus.req0 || !last_one);
  assign pick_oh    = pick1 ? 2'b10 : 2'b01;
  assign len_sel    = pick1 ? bus.len1 : bus.len0;
  assign data_sel   = grant_q[1] ? bus.data1 : bus.data0;
  assign rd_pending = |rd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      grant_q   <= 2'b00;
      cs_q      <= 1'b1;
      data_q    <= '0;
      rd_q      <= 2'b00;
      done_q    <= 2'b00;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      last_one  <= 1'b1;
      len_q     <= '0;
      remaining <= '0;
      pf_data   <= '0;
      pf_full   <= 1'b0;
      tmo_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      rd_q   <= 2'b00;
      done_q <= 2'b00;
      err_q  <= 1'b0;

      case (state)
        IDLE: begin
          cs_q <= 1'b1;
          if (bus.req0 || bus.req1) begin
            grant_q  <= pick_oh;
            last_one <= pick1;
            len_q    <= len_sel;
            busy_q   <= 1'b1;
            if (len_sel == '0) begin
              done_q  <= pick_oh;
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              // First byte is popped during LOAD and captured at its end.
              rd_q  <= pick_oh;
              state <= LOAD;
            end
          end
        end

        LOAD: begin
          cs_q      <= 1'b1;
          data_q    <= data_sel;
          remaining <= len_q - LEN_W'(1);
          pf_full   <= 1'b0;
          tmo_cnt   <= '0;
          state     <= SHIFT;
        end

        SHIFT: begin
          cs_q <= 1'b0;
          if (bus.spi_valid) begin
            tmo_cnt <= '0;
            if (remaining == '0) begin
              cs_q    <= 1'b1;
              done_q  <= grant_q;
              pf_full <= 1'b0;
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              // A pop still in flight is taken straight from the requester.
              data_q    <= pf_full ? pf_data : data_sel;
              pf_full   <= 1'b0;
              remaining <= remaining - LEN_W'(1);
            end
          end else if (tmo_cnt == TMO_LAST) begin
            cs_q    <= 1'b1;
            err_q   <= 1'b1;
            done_q  <= grant_q;
            pf_full <= 1'b0;
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (rd_pending) begin
              pf_data <= data_sel;
              pf_full <= 1'b1;
            end else if ((remaining != '0) && !pf_full) begin
              rd_q <= grant_q;
            end
          end
        end

        GAP: begin
          cs_q <= 1'b1;
          if (gap_cnt == GAP_LAST) begin
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          cs_q    <= 1'b1;
          grant_q <= 2'b00;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.rd0      = rd_q[0];
  assign bus.rd1      = rd_q[1];
  assign bus.done0    = done_q[0];
  assign bus.done1    = done_q[1];
  assign bus.grant    = grant_q;
  assign bus.spi_cs   = cs_q;
  assign bus.spi_data = data_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Bench for spi_tx_arbiter: frame vectors, reset/timeout corners and random frames
// checked against a frame-level model of arbitration order and byte streams.
module tb_spi_tx_arbiter;
  localparam int unsigned CS_GAP  = 4;
  localparam int unsigned TIMEOUT = 1024;
  localparam int unsigned LEN_W   = 4;

  logic clk;
  logic reset;

  spi_tx_arbiter_if #(.LEN_W(LEN_W)) bus ();

  spi_tx_arbiter #(.CS_GAP(CS_GAP), .TIMEOUT(TIMEOUT), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit r0;
    bit r1;
    int l0;
    int l1;
    bit stall;
    bit fixed;
    int exp_first;
    int exp_rd0;
    int exp_rd1;
    int exp_err;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  // Requester byte streams (written by the stimulus only) and monitor state.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int idx0 = 0, idx1 = 0;
  int rd_cnt0 = 0, rd_cnt1 = 0, done_cnt0 = 0, done_cnt1 = 0;
  int err_cnt = 0, err_nodone = 0, cs_low_cnt = 0, gap_viol = 0;
  int hi_run = 0, sh_cnt = 0;
  bit seen_low = 0, valid_prev = 0, rd0_prev = 0, rd1_prev = 0, v_now;
  bit sh_stall = 0;
  int sh_period = 48;
  logic [7:0] sent_b[$];
  logic [1:0] sent_g[$];
  logic [7:0] after_b[$];
  logic       after_cs[$];
  int model_last = 1;

  task automatic check(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Requester FIFOs, shifter model and protocol monitor, all on the falling edge.
  always @(negedge clk) begin
    if (valid_prev) begin
      after_b.push_back(bus.spi_data);
      after_cs.push_back(bus.spi_cs);
    end
    if (rd0_prev) begin rd_cnt0++; idx0++; end
    if (rd1_prev) begin rd_cnt1++; idx1++; end
    rd0_prev  = bus.rd0;
    rd1_prev  = bus.rd1;
    bus.data0 = (idx0 < q0.size()) ? q0[idx0] : 8'h00;
    bus.data1 = (idx1 < q1.size()) ? q1[idx1] : 8'h00;
    if (bus.done0) done_cnt0++;
    if (bus.done1) done_cnt1++;
    if (bus.err) begin
      err_cnt++;
      if (!(bus.done0 || bus.done1)) err_nodone++;
    end
    if (!bus.spi_cs) begin
      cs_low_cnt++;
      if (seen_low && hi_run > 0 && hi_run < int'(CS_GAP)) gap_viol++;
      seen_low = 1;
      hi_run   = 0;
    end else begin
      hi_run++;
    end
    v_now = 0;
    if (!bus.spi_cs && !sh_stall) begin
      sh_cnt++;
      if (sh_cnt >= sh_period) begin
        v_now  = 1;
        sh_cnt = 0;
        sent_b.push_back(bus.spi_data);
        sent_g.push_back(bus.grant);
      end
    end else begin
      sh_cnt = 0;
    end
    bus.spi_valid = v_now;
    valid_prev    = v_now;
  end

  task automatic do_frames(input vec_t v, input int period);
    int s_rd0, s_rd1, s_d0, s_d1, s_err, s_sent, s_after, s_cs, n, na;
    bit act0, act1, last;
    int served[$];
    int got[$];
    logic [7:0] e0[$];
    logic [7:0] e1[$];
    logic [7:0] exp_b[$];
    int exp_o[$];
    s_rd0 = rd_cnt0; s_rd1 = rd_cnt1; s_d0 = done_cnt0; s_d1 = done_cnt1;
    s_err = err_cnt; s_sent = sent_b.size(); s_after = after_b.size(); s_cs = cs_low_cnt;
    if (v.fixed) begin
      q0.push_back(8'hA5); q0.push_back(8'h3C); q0.push_back(8'hFF);
    end
    while (q0.size() < idx0 + v.l0) q0.push_back(8'($urandom));
    while (q1.size() < idx1 + v.l1) q1.push_back(8'($urandom));
    if (v.r0) for (int k = 0; k < v.l0; k++) e0.push_back(q0[idx0 + k]);
    if (v.r1) for (int k = 0; k < v.l1; k++) e1.push_back(q1[idx1 + k]);
    if (v.r0 && v.r1) begin
      served.push_back(v.exp_first);
      served.push_back(1 - v.exp_first);
    end else begin
      served.push_back(v.r1 ? 1 : 0);
    end
    if (!v.stall) begin
      foreach (served[i]) begin
        if (served[i] == 0) foreach (e0[k]) begin exp_b.push_back(e0[k]); exp_o.push_back(0); end
        else foreach (e1[k]) begin exp_b.push_back(e1[k]); exp_o.push_back(1); end
      end
    end
    sh_stall  = v.stall;
    sh_period = period;
    bus.len0  = LEN_W'(v.l0);
    bus.len1  = LEN_W'(v.l1);
    bus.req0  = v.r0;
    bus.req1  = v.r1;
    act0 = v.r0;
    act1 = v.r1;
    for (int cyc = 0; cyc < 20000 && (act0 || act1); cyc++) begin
      @(negedge clk);
      if (act0 && bus.done0) begin bus.req0 = 0; act0 = 0; got.push_back(0); end
      if (act1 && bus.done1) begin bus.req1 = 0; act1 = 0; got.push_back(1); end
    end
    if (act0 || act1) check("frame_complete", 0, 1);
    repeat (CS_GAP + 3) @(negedge clk);
    check("idle_grant", bus.grant, 0);
    check("idle_busy", bus.busy, 0);
    check("idle_cs", bus.spi_cs, 1);
    check("first_owner", (got.size() > 0) ? got[0] : -1, v.exp_first);
    check("served_count", got.size(), served.size());
    check("rd0_count", rd_cnt0 - s_rd0, v.exp_rd0);
    check("rd1_count", rd_cnt1 - s_rd1, v.exp_rd1);
    check("done0_count", done_cnt0 - s_d0, v.r0 ? 1 : 0);
    check("done1_count", done_cnt1 - s_d1, v.r1 ? 1 : 0);
    check("err_count", err_cnt - s_err, v.exp_err);
    n = sent_b.size() - s_sent;
    check("byte_count", n, exp_b.size());
    na = after_b.size() - s_after;
    for (int k = 0; k < n && k < exp_b.size(); k++) begin
      check("byte_value", sent_b[s_sent + k], exp_b[k]);
      check("byte_grant", sent_g[s_sent + k], (exp_o[k] == 1) ? 2 : 1);
      if (k < na) begin
        last = (k + 1 >= exp_b.size()) || (exp_o[k] != exp_o[k + 1]);
        if (!last) check("next_byte_timing", after_b[s_after + k], exp_b[k + 1]);
        check("cs_after_valid", after_cs[s_after + k], last);
      end
    end
    if (v.stall)
      check("timeout_cs_window",
            ((cs_low_cnt - s_cs) >= int'(TIMEOUT) - 2) && ((cs_low_cnt - s_cs) <= int'(TIMEOUT)), 1);
    else if (exp_b.size() == 0)
      check("cs_never_low", cs_low_cnt - s_cs, 0);
    model_last = served[served.size() - 1];
  endtask

  vec_t vecs[7];
  vec_t rv;
  int s_done, s_sent_r;
  bit seen;

  initial begin
    vecs[0] = '{r0:1, r1:1, l0:2,  l1:2,  stall:0, fixed:0, exp_first:0, exp_rd0:2,  exp_rd1:2,  exp_err:0};
    vecs[1] = '{r0:1, r1:0, l0:3,  l1:0,  stall:0, fixed:1, exp_first:0, exp_rd0:3,  exp_rd1:0,  exp_err:0};
    vecs[2] = '{r0:1, r1:1, l0:1,  l1:4,  stall:0, fixed:0, exp_first:1, exp_rd0:1,  exp_rd1:4,  exp_err:0};
    vecs[3] = '{r0:0, r1:1, l0:0,  l1:15, stall:0, fixed:0, exp_first:1, exp_rd0:0,  exp_rd1:15, exp_err:0};
    vecs[4] = '{r0:1, r1:1, l0:15, l1:15, stall:0, fixed:0, exp_first:0, exp_rd0:15, exp_rd1:15, exp_err:0};
    vecs[5] = '{r0:1, r1:0, l0:0,  l1:0,  stall:0, fixed:0, exp_first:0, exp_rd0:0,  exp_rd1:0,  exp_err:0};
    vecs[6] = '{r0:0, r1:1, l0:0,  l1:2,  stall:1, fixed:0, exp_first:1, exp_rd0:0,  exp_rd1:2,  exp_err:1};

    reset = 1'b0;
    bus.req0 = 0; bus.req1 = 0; bus.len0 = '0; bus.len1 = '0;
    #12;
    check("rst_cs", bus.spi_cs, 1);
    check("rst_data", bus.spi_data, 0);
    check("rst_grant", bus.grant, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rd", {bus.rd0, bus.rd1}, 0);
    check("rst_done_err", {bus.done0, bus.done1, bus.err}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) do_frames(vecs[i], 48);

    // Reset in the middle of the second byte of a four-byte frame.
    sh_stall = 0; sh_period = 48;
    while (q0.size() < idx0 + 4) q0.push_back(8'($urandom));
    s_sent_r = sent_b.size();
    bus.len0 = LEN_W'(4);
    bus.req0 = 1;
    seen = 0;
    for (int cyc = 0; cyc < 1000 && !seen; cyc++) begin
      @(negedge clk);
      seen = (sent_b.size() > s_sent_r);
    end
    check("reset_frame_started", seen, 1);
    repeat (10) @(negedge clk);
    s_done = done_cnt0 + done_cnt1;
    #2 reset = 1'b0;
    #1;
    check("async_rst_cs", bus.spi_cs, 1);
    check("async_rst_grant", bus.grant, 0);
    check("async_rst_busy", bus.busy, 0);
    @(negedge clk);
    bus.req0 = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("no_done_on_reset", done_cnt0 + done_cnt1 - s_done, 0);
    model_last = 1;
    rv = '{r0:0, r1:1, l0:0, l1:2, stall:0, fixed:0, exp_first:1, exp_rd0:0, exp_rd1:2, exp_err:0};
    do_frames(rv, 48);

    // Random frames against the arbitration and byte-stream model.
    for (int it = 0; it < 10; it++) begin
      rv.r0 = 1'($urandom_range(0, 1));
      rv.r1 = 1'($urandom_range(0, 1));
      if (!rv.r0 && !rv.r1) rv.r0 = 1;
      rv.l0 = rv.r0 ? int'($urandom_range(0, 15)) : 0;
      rv.l1 = rv.r1 ? int'($urandom_range(0, 15)) : 0;
      rv.stall = 0;
      rv.fixed = 0;
      if (rv.r0 && rv.r1) rv.exp_first = (model_last == 0) ? 1 : 0;
      else rv.exp_first = rv.r1 ? 1 : 0;
      rv.exp_rd0 = rv.l0;
      rv.exp_rd1 = rv.l1;
      rv.exp_err = 0;
      do_frames(rv, int'($urandom_range(9, 20)));
    end

    check("cs_gap_violations", gap_viol, 0);
    check("err_without_done", err_nodone, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/spi_tx_arbiter.md
Name: spi_tx_arbiter

Overview:
- Shares the single SPI byte-transmit shifter between two frame requesters, e.g. the floor display driver and the status LED driver.
- Grants one requester per frame and drives the shifter's active-low chip select and byte input.
- Prefetches the next byte so it is ready when the shifter completes the current one, and handles gaps, timeouts and completion signalling.

Parameters:
CS_GAP, 4, cycles chip select is held high after a frame before the next grant; minimum 1
TIMEOUT, 1024, max clk cycles to wait for spi_valid per byte before aborting the frame
LEN_W, 4, width of frame length field; frame length 0..2^LEN_W-1 bytes

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req0  in  1  requester 0 frame request; level, sampled only in IDLE
len0  in  LEN_W  requester 0 frame byte count; sampled with grant
data0  in  8  requester 0 current byte; first-word-fall-through, valid whenever rd0 pulses
rd0  out  1  one-cycle pop of data0; byte sampled the same cycle
done0  out  1  one-cycle pulse when requester 0 frame ends (normal or abort)
req1, len1, data1, rd1, done1  same as above for requester 1
grant  out  2  one-hot owner of the shifter; 00 when idle
spi_cs  out  1  to shifter cs, active-low
spi_data  out  8  to shifter data_in
spi_valid  in  1  shifter byte-complete pulse
busy  out  1  high in any state other than IDLE
err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset state: spi_cs=1, spi_data=0, grant=00, rd*/done*/err=0, busy=0, round-robin pointer set so requester 0 wins the first tie.
- Reset mid-frame: spi_cs rises immediately; any partial frame is discarded and no done is issued.
- FSM states: IDLE, LOAD, SHIFT, GAP. All outputs are registered.
- IDLE:
  - Only req alone -> grant that requester.
  - Both req -> grant the requester not served last, then toggle the pointer.
  - Latch len, set grant; go to LOAD.
  - len==0 -> pulse done, go to GAP, spi_cs stays high.
- LOAD (1 cycle):
  - spi_data <= granted data; pulse rd; remaining <= len-1.
  - Next cycle: spi_cs=0, enter SHIFT, clear timeout counter.
  - spi_data is therefore stable at least 1 cycle before cs falls.
- SHIFT prefetch: if remaining>0 and the prefetch register is empty, sample data into it, pulse rd, mark it full. At most one prefetch is outstanding.
- SHIFT, on spi_valid:
  - remaining>0: spi_data <= prefetch on the next edge (within 1 cycle of valid, required by shifter timing); mark prefetch empty; remaining -= 1; reset timeout counter.
  - remaining==0: spi_cs <= 1, pulse done for the owner, go to GAP.
- Timeout: the counter increments each SHIFT cycle without spi_valid. Reaching TIMEOUT-1 -> spi_cs <= 1, err and done pulse, prefetched byte dropped, go to GAP.
- GAP: spi_cs=1, grant held, count CS_GAP cycles, then grant <= 00 and return to IDLE.
- Requesters must drop req within CS_GAP cycles of done; req still high in IDLE starts a new frame.
- During a frame, req and len changes are ignored. spi_valid outside SHIFT is ignored.
- rd pulses per frame == len exactly on normal completion; <= len on abort.
- Round-robin pointer updates only on grant, never on reset-free idle cycles.

Test Plan:
- Single frame: req0=1, len0=3, data0 stream A5,3C,FF, shifter model pulses valid every 48 cycles -> spi_data sequence A5,3C,FF; cs low for exactly 3 valids; rd0 pulsed 3 times; done0 once; grant=01 throughout.
- Contention: req0 and req1 both high from reset, len=2 each -> req0 served first, then after CS_GAP=4 high cycles req1 served; next simultaneous request goes to req0 again only after req1 was served.
- Back-to-back data timing: spi_valid pulse for byte 1 -> spi_data shows byte 2 on the very next cycle; check across len=15 frame (max) with no rd underrun.
- Timeout: len1=2, shifter stalled (no valid) -> after 1024 SHIFT cycles err and done1 pulse together, cs high, grant cleared after gap, rd1 count=2.
- Zero length and reset: len0=0 -> done0 pulse, cs never low. Assert reset low mid-byte of a len=4 frame -> cs=1 and grant=00 asynchronously, no done; after release a fresh req1 is granted first.
